// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ALU control decoder side and the EX/MEM result path.
// The master drives requests and accepts results. The slave (the execution unit)
// accepts requests and presents registered results.
//   in_valid/in_ready : request handshake carrying ctrl, a, b, shamt
//   out_valid/out_ready : result handshake carrying result, zero, overflow, err
interface alu_exec_unit_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(W)
) ();
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ctrl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          err;

  modport master (
    output in_valid, ctrl, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, err
  );

  modport slave (
    input  in_valid, ctrl, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS EX-stage execution unit driven by the 4-bit ALU control code.
// Logic/arithmetic ops finish one cycle after accept. Shifts run one bit per cycle,
// so a shift of n takes n+1 cycles. Results are held until taken downstream.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : slave side of alu_exec_unit_if (request in, result/flags out)
module alu_exec_unit #(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = $clog2(W)
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [1:0]    sop_q, sop_d;
  logic [W-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;

  logic [W-1:0]  sum, diff, alu_res, shifted;
  logic          alu_ov, alu_err, is_shift;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  // Single-cycle datapath; shift codes return b so shamt=0 completes here.
  always_comb begin
    alu_res  = '0;
    alu_ov   = 1'b0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    case (bus.ctrl)
      4'b0000: alu_res = bus.a & bus.b;
      4'b0001: alu_res = bus.a | bus.b;
      4'b0010: begin
        alu_res = sum;
        alu_ov  = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      4'b0110: begin
        alu_res = diff;
        alu_ov  = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      4'b0111: alu_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1100: alu_res = ~(bus.a | bus.b);
      4'b1000, 4'b1001, 4'b1010: begin
        alu_res  = bus.b;
        is_shift = 1'b1;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter; sop_q holds ctrl[1:0] of the shift op.
  always_comb begin
    unique case (sop_q)
      2'b00:   shifted = {shreg_q[W-2:0], 1'b0};
      2'b01:   shifted = {1'b0, shreg_q[W-1:1]};
      default: shifted = {shreg_q[W-1], shreg_q[W-1:1]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    sop_d      = sop_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (is_shift && (bus.shamt != '0)) begin
            shreg_d = bus.b;
            cnt_d   = bus.shamt;
            sop_d   = bus.ctrl[1:0];
            state_d = StShift;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == '0);
            overflow_d = alu_ov;
            err_d      = alu_err;
            state_d    = StDone;
          end
        end
      end
      StShift: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          result_d   = shifted;
          zero_d     = (shifted == '0);
          overflow_d = 1'b0;
          err_d      = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      sop_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sop_q      <= sop_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.W(W)) bus ();
  alu_exec_unit #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares each result at the cycle it is taken.
  exp_t m;
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h want none", bus.result);
      end else begin
        m = sb.pop_front();
        check("result", bus.result, m.res);
        check("zero", 32'(bus.zero), 32'(m.z));
        check("overflow", 32'(bus.overflow), 32'(m.ov));
        check("err", 32'(bus.err), 32'(m.e));
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input exp_t e, input bit push);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
    end
    bus.ctrl     = c;
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts cycles from accept to out_valid; in_ready must stay low the whole time.
  task automatic wait_out(input string name, input int exp_lat);
    int lat  = 0;
    int busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.in_ready) busy++;
    end while (!bus.out_valid && lat < 100);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy"}, 32'(busy), 32'(exp_lat));
  endtask

  task automatic after_take(input string name);
    @(posedge clk);
    #1;
    check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                        input logic z, input logic ov, input logic e, input int lat);
    exp_t x;
    x = '{res: res, z: z, ov: ov, e: e};
    send(c, a, b, sh, x, 1'b1);
    wait_out(name, lat);
    after_take(name);
  endtask

  exp_t tmp;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.ctrl      = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // Arithmetic and logic
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 0, 1, 0, 1);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'h0, 1, 0, 0, 1);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 0, 0, 0, 1);
    run_op("slt_false", 4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1, 0, 0, 1);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 0, 1, 0, 1);
    run_op("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 32'hF0F0_FF00, 0, 0, 0, 1);

    // Shifts
    run_op("sra4", 4'b1010, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0, 0, 0, 5);
    run_op("sll31", 4'b1000, 32'h0, 32'h1, 5'd31, 32'h8000_0000, 0, 0, 0, 32);
    run_op("srl0", 4'b1001, 32'h0, 32'h1234_5678, 5'd0, 32'h1234_5678, 0, 0, 0, 1);
    run_op("srl31", 4'b1001, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 0, 0, 0, 32);
    run_op("srl_pos", 4'b1001, 32'h0, 32'hF000_000F, 5'd4, 32'h0F00_0000, 0, 0, 0, 5);

    // Back-pressure: result held, new request ignored
    bus.out_ready = 1'b0;
    tmp = '{res: 32'h0000_F000, z: 1'b0, ov: 1'b0, e: 1'b0};
    send(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, tmp, 1'b1);
    wait_out("and_hold", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_result", bus.result, 32'h0000_F000);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 0) begin
        bus.ctrl     = 4'b0001;
        bus.a        = 32'h1111_0000;
        bus.b        = 32'h0000_2222;
        bus.in_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    after_take("and_hold");

    // Illegal code, then a legal op clears err
    run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 5'd0, 32'h0, 1, 0, 1, 1);
    run_op("or_clear", 4'b0001, 32'h1, 32'h2, 5'd0, 32'h3, 0, 0, 0, 1);

    // Reset aborts an in-flight shift
    tmp = '{res: 32'h0, z: 1'b0, ov: 1'b0, e: 1'b0};
    send(4'b1001, 32'h0, 32'hFFFF_FFFF, 5'd20, tmp, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
